receive_check: RTL
==================

// Module: receive_check
// PURPOSE
//   Receive-side checker for the 10-bit {parity, count} word from the transmit stage.
//   - Verifies even parity on every sampled word.
//   - Locks onto the incrementing count sequence and flags gaps and repeats.
//   - Forwards good words downstream and keeps a saturating error tally.
//   Sits directly downstream of transmit, on the same clk.
// PARAMETERS
//   DATA_W      9   payload width; the input word is DATA_W+1 bits (MSB = parity)
//   LOCK_COUNT  4   consecutive good, in-sequence words needed to declare lock
//   LOSS_COUNT  3   consecutive bad words (parity or sequence) that drop lock
//   ERR_W       16  width of the saturating error counter
// PORTS
//   clk         in   1         single clock, rising edge
//   clear       in   1         synchronous, active-high reset
//   valid       in   1         data_in holds a new word this cycle
//   data_in     in   DATA_W+1  {parity, payload}; parity is the even-parity bit
//   word_out    out  DATA_W    last forwarded payload
//   word_valid  out  1         1-cycle pulse: word_out updated
//   locked      out  1         high while in LOCKED
//   parity_err  out  1         1-cycle pulse: sampled word failed parity
//   seq_err     out  1         1-cycle pulse: good-parity word != expected (LOCKED only)
//   err_count   out  ERR_W     number of erroneous words, saturates at all-ones
// BEHAVIOUR
//   Reset and clocking
//   - clear wins over valid. All outputs, exp, run and miss go to 0; state goes to HUNT.
//   - All outputs are registered. Flags and pulses appear 1 cycle after the word is sampled.
//   - valid low: no state or counter change; all pulses low.
//   Checks (exp and sequence arithmetic are mod 2^DATA_W, so 511 -> 0 is in sequence)
//   - par_ok = (number of ones across all DATA_W+1 bits is even).
//   States:
//   - HUNT: par_ok -> exp<=payload+1, run<=1, go to VERIFY.
//     Parity failure -> parity_err; stay in HUNT.
//   - VERIFY: par_ok & payload==exp -> run++, exp<=payload+1; at run==LOCK_COUNT go to LOCKED, miss<=0.
//     par_ok & mismatch -> run<=1, exp<=payload+1; stay in VERIFY; no seq_err.
//     Parity failure -> parity_err; go to HUNT.
//   - LOCKED: par_ok -> word_out<=payload, word_valid.
//     On a match: miss<=0.
//     On a mismatch: seq_err, miss++.
//     Parity failure -> parity_err, miss++; the word is not forwarded.
//     Flywheel: exp<=exp+1 on every sampled word, good or bad.
//     miss reaching LOSS_COUNT -> go to HUNT; locked falls on the same edge.
//   - No word is forwarded outside LOCKED.
//   Error counting
//   - err_count += 1 per word with parity_err or seq_err, in any state.
//   - A word with both errors counts once. The counter holds at 2^ERR_W-1.
//   - A transmit-side count reset shows up as sequence errors until lock is lost, then relock proceeds normally.
//   - clear mid-stream: relock needs LOCK_COUNT fresh words.
// STRUCTURE
//   - Shared header transmit_defs.vh: state encodings HUNT=2'd0, VERIFY=2'd1, LOCKED=2'd2, plus the default DATA_W.
//   - Sub-module: reuse hc280 on data_in[8:0]; par_ok = (odd == data_in[9]). Generate a reduction XOR when DATA_W != 9.
//   - One FSM always block and one datapath always block.
// TESTING
//   1. clear, then payloads 0,1,2,3,4 on consecutive valid cycles
//      -> locked rises after word 3 is sampled; word 4 gives word_out=4 with word_valid; no errors.
//   2. Locked; send 509,510,511,0,1 -> word_valid each cycle, word_out wraps 511->0, seq_err never set.
//   3. Locked at exp=0x0A5; send payload 0x0A5 with the parity bit inverted
//      -> parity_err pulse, err_count=1, no word_valid, locked stays; 0x0A6 is then accepted.
//   4. Locked after 100; send 0,1,2 -> seq_err x3, err_count=3, locked low after the 3rd;
//      then 3,4,5,6 relocks -> locked high.
//   5. Idle valid gaps mid-stream: no pulses, exp unchanged. clear and valid high together -> all outputs 0, state HUNT.
//   6. ERR_W=2: five parity errors -> err_count saturates at 3; clear -> 0.

Source files
------------

// File: rtl/receive_check_pkg.sv
// receive_check_pkg: shared state encoding and default payload width
package receive_check_pkg;
  localparam int DATA_W_DEF = 9;
  typedef enum logic [1:0] {
    HUNT   = 2'd0,
    VERIFY = 2'd1,
    LOCKED = 2'd2
  } state_t;
endpackage

// File: rtl/receive_check_hc280.sv
// hc280: 9-bit odd/even parity generator in the style of the 74HC280
module hc280 (
  input  logic [8:0] d,
  output logic       odd,
  output logic       even
);
  assign odd  = ^d;
  assign even = ~odd;
endmodule

// File: rtl/receive_check.sv
// receive_check: parity and sequence checker for the transmit {parity, count} word
module receive_check
  import receive_check_pkg::*;
#(
  parameter int DATA_W     = DATA_W_DEF,
  parameter int LOCK_COUNT = 4,
  parameter int LOSS_COUNT = 3,
  parameter int ERR_W      = 16
) (
  input  logic              clk,
  input  logic              clear,
  input  logic              valid,
  input  logic [DATA_W:0]   data_in,
  output logic [DATA_W-1:0] word_out,
  output logic              word_valid,
  output logic              locked,
  output logic              parity_err,
  output logic              seq_err,
  output logic [ERR_W-1:0]  err_count
);
  localparam int RUN_W  = $clog2(LOCK_COUNT + 1);
  localparam int MISS_W = $clog2(LOSS_COUNT + 1);
  state_t            state;
  logic [DATA_W-1:0] exp;
  logic [RUN_W-1:0]  run;
  logic [MISS_W-1:0] miss;
  logic [DATA_W-1:0] payload;
  logic              odd, even, par_ok, match, in_lock, fwd, perr, serr;
  logic [RUN_W-1:0]  run_inc;
  logic [MISS_W-1:0] miss_inc;
  assign payload  = data_in[DATA_W-1:0];
  generate
    if (DATA_W == 9) begin : g_hc280
      hc280 u_hc280 (.d(payload), .odd(odd), .even(even));
    end else begin : g_xor
      assign odd  = ^payload;
      assign even = ~odd;
    end
  endgenerate
  assign par_ok   = data_in[DATA_W] ? odd : even;
  assign match    = payload == exp;
  assign in_lock  = state == LOCKED;
  assign fwd      = valid && par_ok && in_lock;
  assign perr     = valid && !par_ok;
  assign serr     = fwd && !match;
  assign run_inc  = run + RUN_W'(1);
  assign miss_inc = miss + MISS_W'(1);
  // lock state machine: hunt, verify a run of in-sequence words, then flywheel
  always_ff @(posedge clk) begin
    if (clear) begin
      state      <= HUNT;
      exp        <= '0;
      run        <= '0;
      miss       <= '0;
      locked     <= 1'b0;
      parity_err <= 1'b0;
      seq_err    <= 1'b0;
    end else begin
      parity_err <= perr;
      seq_err    <= serr;
      if (valid) begin
        unique case (state)
          HUNT: if (par_ok) begin
            state <= VERIFY;
            exp   <= payload + DATA_W'(1);
            run   <= RUN_W'(1);
          end
          VERIFY: if (!par_ok) begin
            state <= HUNT;
            run   <= '0;
          end else begin
            exp <= payload + DATA_W'(1);
            run <= match ? run_inc : RUN_W'(1);
            if (match && run_inc == RUN_W'(LOCK_COUNT)) begin
              state  <= LOCKED;
              locked <= 1'b1;
              miss   <= '0;
            end
          end
          LOCKED: begin
            exp <= exp + DATA_W'(1);
            if (par_ok && match) miss <= '0;
            else if (miss_inc == MISS_W'(LOSS_COUNT)) begin
              state  <= HUNT;
              locked <= 1'b0;
              run    <= '0;
              miss   <= '0;
            end else miss <= miss_inc;
          end
          default: state <= HUNT;
        endcase
      end
    end
  end
  // datapath: forward good words while locked and keep a saturating error tally
  always_ff @(posedge clk) begin
    if (clear) begin
      word_out   <= '0;
      word_valid <= 1'b0;
      err_count  <= '0;
    end else begin
      word_valid <= fwd;
      if (fwd) word_out <= payload;
      if ((perr || serr) && !(&err_count)) err_count <= err_count + ERR_W'(1);
    end
  end
endmodule
